// File: rtl/dram_axil_pkg.sv
// dram_axil_pkg: shared state/response types and default geometry for the
// DRAM responder and its word store.
package dram_axil_pkg;

  localparam int          DRAM_DEPTH = 256;
  localparam logic [16:0] DRAM_BASE  = 17'h10000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_R_LAT  = 3'd1,
    ST_R_RESP = 3'd2,
    ST_W_DATA = 3'd3,
    ST_W_LAT  = 3'd4,
    ST_B_RESP = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

endpackage

// File: rtl/dram_axil_mem.sv
// dram_axil_mem: single-port word store. The read register only updates on
// re, so it holds the response word until the next read.
module dram_axil_mem
  import dram_axil_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int N_WORDS = DRAM_DEPTH,
  parameter int IDX_W   = $clog2(N_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              zero,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [N_WORDS];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= zero ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/dram_axil_responder.sv
// dram_axil_responder: AXI4-Lite-style DRAM endpoint, one transaction at a time
// with a fixed LAT-cycle response latency. Define DRAM_ERR_RESP_EN for SLVERR checks.
module dram_axil_responder
  import dram_axil_pkg::*;
#(
  parameter int                ADDR_W = 17,
  parameter int                DATA_W = 64,
  parameter int                DEPTH  = DRAM_DEPTH,
  parameter logic [ADDR_W-1:0] BASE   = DRAM_BASE,
  parameter int                LAT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AR_VALID,
  input  logic [ADDR_W-1:0] AR_ADDR,
  output logic              AR_READY,
  output logic              R_VALID,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  input  logic              R_READY,
  input  logic              AW_VALID,
  input  logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_READY,
  input  logic              W_VALID,
  input  logic [DATA_W-1:0] W_DATA,
  output logic              W_READY,
  output logic              B_VALID,
  output logic [1:0]        B_RESP,
  input  logic              B_READY
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] LAT_LD = 4'(LAT - 1);

  state_t              state, next;
  logic [ADDR_W-1:0]   addr_q, cur_addr;
  logic [DATA_W-1:0]   wdata_q, mem_wdata;
  logic [3:0]          cnt;
  logic [IDX_W-1:0]    idx;
  logic                err, ar_hs, aw_hs, w_hs, mem_re, mem_we, b_load;
  resp_t               resp_code;

  assign AR_READY = (state == ST_IDLE) && !rst;
  assign AW_READY = (state == ST_IDLE) && !rst && !AR_VALID;
  assign W_READY  = (state == ST_W_DATA);
  assign R_VALID  = (state == ST_R_RESP);
  assign B_VALID  = (state == ST_B_RESP);

  assign ar_hs = AR_VALID && AR_READY;
  assign aw_hs = AW_VALID && AW_READY;
  assign w_hs  = W_VALID && W_READY;

  // With LAT=1 the access fires on the handshake itself, before addr_q/wdata_q load.
  assign cur_addr  = (state == ST_IDLE) ? AR_ADDR : addr_q;
  assign mem_wdata = (state == ST_W_DATA) ? W_DATA : wdata_q;
  assign idx       = IDX_W'((cur_addr - BASE) >> 3);

`ifdef DRAM_ERR_RESP_EN
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W+1)'(DEPTH * 8);
  assign err = ({1'b0, cur_addr} < {1'b0, BASE}) || ({1'b0, cur_addr} >= LIMIT) ||
               (cur_addr[2:0] != 3'b000);
`else
  assign err = 1'b0;
`endif

  assign resp_code = err ? RESP_SLVERR : RESP_OKAY;
  assign mem_we    = b_load && !err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next   = state;
    mem_re = 1'b0;
    b_load = 1'b0;
    if (rst) begin
      next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            next   = (LAT == 1) ? ST_R_RESP : ST_R_LAT;
            mem_re = (LAT == 1);
          end else if (aw_hs) begin
            next = ST_W_DATA;
          end else begin
            next = ST_IDLE;
          end
        end
        ST_R_LAT: begin
          if (cnt == 4'd1) begin
            next   = ST_R_RESP;
            mem_re = 1'b1;
          end else begin
            next = ST_R_LAT;
          end
        end
        ST_W_DATA: begin
          if (w_hs) begin
            next   = (LAT == 1) ? ST_B_RESP : ST_W_LAT;
            b_load = (LAT == 1);
          end else begin
            next = ST_W_DATA;
          end
        end
        ST_W_LAT: begin
          if (cnt == 4'd1) begin
            next   = ST_B_RESP;
            b_load = 1'b1;
          end else begin
            next = ST_W_LAT;
          end
        end
        ST_R_RESP: begin
          if (R_READY) begin
            next = ST_IDLE;
          end else begin
            next = ST_R_RESP;
          end
        end
        ST_B_RESP: begin
          if (B_READY) begin
            next = ST_IDLE;
          end else begin
            next = ST_B_RESP;
          end
        end
        default: next = ST_IDLE;
      endcase
    end
  end

  // Request capture, latency counter and held response codes.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= 4'd0;
      R_RESP  <= 2'b00;
      B_RESP  <= 2'b00;
    end else begin
      if (ar_hs) begin
        addr_q <= AR_ADDR;
      end else if (aw_hs) begin
        addr_q <= AW_ADDR;
      end
      if (w_hs) begin
        wdata_q <= W_DATA;
      end
      if (ar_hs || w_hs) begin
        cnt <= LAT_LD;
      end else if ((state == ST_R_LAT || state == ST_W_LAT) && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (mem_re) begin
        R_RESP <= resp_code;
      end
      if (b_load) begin
        B_RESP <= resp_code;
      end
    end
  end

  dram_axil_mem #(
    .DATA_W  (DATA_W),
    .N_WORDS (DEPTH),
    .IDX_W   (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .zero  (err),
    .idx   (idx),
    .wdata (mem_wdata),
    .rdata (R_DATA)
  );

endmodule

// File: tb/tb_dram_axil_responder.sv
// tb_dram_axil_responder: vector table, directed corner sequences and a
// randomized phase checked against an address-rule memory model.
module tb_dram_axil_responder;

  localparam int LAT     = 4;
  localparam int BASE_I  = 32'h10000;
  localparam int DEPTH_I = 256;
`ifdef DRAM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [16:0] AR_ADDR, AW_ADDR;
  logic [63:0] R_DATA, W_DATA;
  logic [1:0]  R_RESP, B_RESP;

  dram_axil_responder #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] model [int];

  typedef struct {
    bit          wr;
    logic [16:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;
  vec_t tbl [14];

  function automatic bit exp_err(logic [16:0] a);
    int unsigned u = {15'd0, a};
    return ERR_EN && (u < BASE_I || u >= BASE_I + DEPTH_I * 8 || u % 8 != 0);
  endfunction

  function automatic int exp_idx(logic [16:0] a);
    int unsigned d = {15'd0, a} - BASE_I;
    return int'((d / 8) % DEPTH_I);
  endfunction

  task automatic model_write(input logic [16:0] a, input logic [63:0] d);
    if (!exp_err(a)) model[exp_idx(a)] = d;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete read or write; stall = cycles the response is left pending.
  task automatic xact(input bit wr, input logic [16:0] a, input logic [63:0] d, input int stall,
                      output logic [1:0] resp, output logic [63:0] rdata);
    int n;
    int lat;
    if (wr) begin AW_VALID = 1'b1; AW_ADDR = a; end
    else    begin AR_VALID = 1'b1; AR_ADDR = a; end
    #1;
    n = 0;
    while (!(wr ? AW_READY : AR_READY) && n < 40) begin cyc(); n++; end
    chk("addr_ready_wait", n < 40, 1'b1);
    cyc();
    AW_VALID = 1'b0;
    AR_VALID = 1'b0;
    if (wr) begin
      W_VALID = 1'b1;
      W_DATA  = d;
      #1;
      n = 0;
      while (!W_READY && n < 40) begin cyc(); n++; end
      chk("w_ready_wait", n < 40, 1'b1);
      cyc();
      W_VALID = 1'b0;
    end
    lat = 1;
    while (!(wr ? B_VALID : R_VALID) && lat < 40) begin cyc(); lat++; end
    chk(wr ? "write_latency" : "read_latency", 64'(lat), 64'(LAT));
    resp  = wr ? B_RESP : R_RESP;
    rdata = R_DATA;
    for (int i = 0; i < stall; i++) begin
      cyc();
      chk("hold_valid", wr ? B_VALID : R_VALID, 1'b1);
      chk("hold_resp", wr ? B_RESP : R_RESP, resp);
      if (!wr) chk("hold_data", R_DATA, rdata);
    end
    if (wr) B_READY = 1'b1;
    else    R_READY = 1'b1;
    cyc();
    B_READY = 1'b0;
    R_READY = 1'b0;
    chk("idle_after_resp", {AR_READY, R_VALID, B_VALID}, 3'b100);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [63:0] rdata, exp_d;
    logic [16:0] a;
    logic [63:0] d;
    int          n, sel;
    bit          wr, seen;

    tbl[0]  = '{1'b1, 17'h10008, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h0};
    tbl[1]  = '{1'b0, 17'h10008, 64'h0, 2'b00, 64'h0123_4567_89AB_CDEF};
    tbl[2]  = '{1'b1, 17'h10000, 64'hA5A5_A5A5_0000_0001, 2'b00, 64'h0};
    tbl[3]  = '{1'b1, 17'h107F8, 64'h5A5A_5A5A_FFFF_0002, 2'b00, 64'h0};
    tbl[4]  = '{1'b1, 17'h10020, 64'hC0FF_EE00_0000_0020, 2'b00, 64'h0};
    tbl[5]  = '{1'b1, 17'h10010, 64'h1111_2222_3333_4444, 2'b00, 64'h0};
    tbl[6]  = '{1'b0, 17'h10000, 64'h0, 2'b00, 64'hA5A5_A5A5_0000_0001};
    tbl[7]  = '{1'b0, 17'h107F8, 64'h0, 2'b00, 64'h5A5A_5A5A_FFFF_0002};
    tbl[8]  = '{1'b0, 17'h10800, 64'h0, ERR_EN ? 2'b10 : 2'b00,
                ERR_EN ? 64'h0 : 64'hA5A5_A5A5_0000_0001};
    tbl[9]  = '{1'b1, 17'h10004, 64'hDEAD_BEEF_0000_0004, ERR_EN ? 2'b10 : 2'b00, 64'h0};
    tbl[10] = '{1'b0, 17'h10000, 64'h0, 2'b00,
                ERR_EN ? 64'hA5A5_A5A5_0000_0001 : 64'hDEAD_BEEF_0000_0004};
    tbl[11] = '{1'b1, 17'h0FFF8, 64'hBADC_0FFE_0000_00FF, ERR_EN ? 2'b10 : 2'b00, 64'h0};
    tbl[12] = '{1'b0, 17'h107F8, 64'h0, 2'b00,
                ERR_EN ? 64'h5A5A_5A5A_FFFF_0002 : 64'hBADC_0FFE_0000_00FF};
    tbl[13] = '{1'b0, 17'h0FFF8, 64'h0, ERR_EN ? 2'b10 : 2'b00,
                ERR_EN ? 64'h0 : 64'hBADC_0FFE_0000_00FF};

    rst = 1'b1;
    AR_VALID = 1'b0; AR_ADDR = '0; R_READY = 1'b0;
    AW_VALID = 1'b0; AW_ADDR = '0; W_VALID = 1'b0; W_DATA = '0; B_READY = 1'b0;
    repeat (3) cyc();
    chk("rst_ar_ready", AR_READY, 1'b0);
    chk("rst_aw_ready", AW_READY, 1'b0);
    chk("rst_valids", {R_VALID, B_VALID, W_READY}, 3'b000);
    chk("rst_r_data", R_DATA, 64'h0);
    chk("rst_resps", {R_RESP, B_RESP}, 4'h0);
    rst = 1'b0;
    #1;
    chk("first_idle_ready", {AR_READY, AW_READY}, 2'b11);

    for (int i = 0; i < 14; i++) begin
      xact(tbl[i].wr, tbl[i].addr, tbl[i].data, i % 3, resp, rdata);
      chk($sformatf("vec%0d_resp", i), resp, tbl[i].resp);
      if (tbl[i].wr) model_write(tbl[i].addr, tbl[i].data);
      else chk($sformatf("vec%0d_data", i), rdata, tbl[i].rdata);
    end

    // R_READY held low for 5 cycles after R_VALID.
    xact(1'b0, 17'h10008, 64'h0, 5, resp, rdata);
    chk("stall_data", rdata, 64'h0123_4567_89AB_CDEF);

    // Simultaneous AR and AW: the read goes first, AW waits for IDLE.
    AR_VALID = 1'b1; AR_ADDR = 17'h10010; AW_VALID = 1'b1; AW_ADDR = 17'h10018;
    #1;
    chk("sim_ready", {AR_READY, AW_READY}, 2'b10);
    cyc();
    AR_VALID = 1'b0;
    #1;
    n = 1; seen = 1'b0;
    while (!R_VALID && n < 40) begin
      if (AW_READY) seen = 1'b1;
      cyc(); n++;
    end
    chk("sim_read_latency", 64'(n), 64'(LAT));
    chk("sim_aw_blocked", {seen, AW_READY}, 2'b00);
    chk("sim_read_data", R_DATA, 64'h1111_2222_3333_4444);
    R_READY = 1'b1;
    cyc();
    R_READY = 1'b0;
    #1;
    chk("sim_aw_ready_idle", AW_READY, 1'b1);
    cyc();
    AW_VALID = 1'b0;
    W_VALID = 1'b1; W_DATA = 64'h7777_8888_9999_AAAA;
    #1;
    chk("sim_w_ready", W_READY, 1'b1);
    cyc();
    W_VALID = 1'b0;
    n = 1;
    while (!B_VALID && n < 40) begin cyc(); n++; end
    chk("sim_write_latency", 64'(n), 64'(LAT));
    chk("sim_b_resp", B_RESP, 2'b00);
    B_READY = 1'b1;
    cyc();
    B_READY = 1'b0;
    model_write(17'h10018, 64'h7777_8888_9999_AAAA);
    xact(1'b0, 17'h10018, 64'h0, 0, resp, rdata);
    chk("sim_readback", rdata, 64'h7777_8888_9999_AAAA);

    // Reset in the last W_LAT cycle: the write must be dropped.
    AW_VALID = 1'b1; AW_ADDR = 17'h10020;
    #1;
    chk("rstw_aw_ready", AW_READY, 1'b1);
    cyc();
    AW_VALID = 1'b0;
    W_VALID = 1'b1; W_DATA = 64'hFFFF_0000_FFFF_0000;
    cyc();
    W_VALID = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("rstw_ready_low", {AR_READY, AW_READY}, 2'b00);
    cyc();
    rst = 1'b0;
    #1;
    chk("rstw_after", {AR_READY, R_VALID, B_VALID, W_READY}, 4'b1000);
    seen = 1'b0;
    repeat (8) begin cyc(); if (B_VALID) seen = 1'b1; end
    chk("rstw_no_b_valid", seen, 1'b0);
    xact(1'b0, 17'h10020, 64'h0, 0, resp, rdata);
    chk("rstw_old_data", rdata, model[exp_idx(17'h10020)]);

    // Back-to-back reads with R_READY tied high.
    R_READY = 1'b1;
    AR_VALID = 1'b1; AR_ADDR = 17'h10000;
    #1;
    chk("b2b_ar0_ready", AR_READY, 1'b1);
    cyc();
    AR_ADDR = 17'h107F8;
    n = 1;
    while (!R_VALID && n < 40) begin cyc(); n++; end
    chk("b2b_lat0", 64'(n), 64'(LAT));
    chk("b2b_data0", R_DATA, model[exp_idx(17'h10000)]);
    cyc();
    chk("b2b_ar1_ready", {AR_READY, R_VALID}, 2'b10);
    cyc();
    AR_VALID = 1'b0;
    n = 1;
    while (!R_VALID && n < 40) begin cyc(); n++; end
    chk("b2b_lat1", 64'(n), 64'(LAT));
    chk("b2b_data1", R_DATA, model[exp_idx(17'h107F8)]);
    cyc();
    R_READY = 1'b0;

    // Randomized traffic against the model.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 17'(BASE_I + 8 * $urandom_range(0, 255));
      else if (sel == 7) a = 17'(BASE_I + 8 * $urandom_range(0, 255) + $urandom_range(1, 7));
      else if (sel == 8) a = 17'(BASE_I + DEPTH_I * 8 + 8 * $urandom_range(0, 63));
      else               a = 17'(BASE_I - 8 * $urandom_range(1, 64));
      wr = ($urandom_range(0, 1) == 1);
      d  = {$urandom, $urandom};
      xact(wr, a, d, $urandom_range(0, 3), resp, rdata);
      chk($sformatf("rnd%0d_resp", t), resp, exp_err(a) ? 2'b10 : 2'b00);
      if (wr) begin
        model_write(a, d);
      end else if (exp_err(a)) begin
        chk($sformatf("rnd%0d_err_data", t), rdata, 64'h0);
      end else if (model.exists(exp_idx(a))) begin
        exp_d = model[exp_idx(a)];
        chk($sformatf("rnd%0d_data", t), rdata, exp_d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
